sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; successor to the fixed 8-bit sync FIFO.

---
 rtl/sync_fifo_param.sv | 96 +++++++++
 tb/tb_sync_fifo_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; the default build has one cycle of read latency.
module sync_fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr,
   input  logic [WIDTH-1:0]         d_in,
   input  logic                     rd,
   output logic [WIDTH-1:0]         d_out,
   output logic                     full,
   output logic                     emp,
   output logic                     a_full,
   output logic                     a_emp,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   output logic                     udf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_inc;
   logic             wr_ok;
   logic             rd_ok;
   logic [CW-1:0]    count_nxt;

   // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
   always_comb begin
      wr_ok      = wr & (~full | rd);
      rd_ok      = rd & ~emp;
      rd_ptr_inc = rd_ptr + 1'b1;
      count_nxt  = count + CW'(wr_ok) - CW'(rd_ok);
   end

   // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok)
         mem[wr_ptr] <= d_in;
   end

   // NOTE: all state uses non-blocking assignments so every update sees the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         d_out  <= '0;
         full   <= 1'b0;
         emp    <= 1'b1;
         a_full <= 1'b0;
         a_emp  <= 1'b1;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok)
            rd_ptr <= rd_ptr_inc;

         count  <= count_nxt;
         full   <= (count_nxt == DEPTH_C);
         emp    <= (count_nxt == '0);
         a_full <= (count_nxt >= AF_C);
         a_emp  <= (count_nxt <= AE_C);
         ovf    <= ovf | (wr & ~wr_ok);
         udf    <= udf | (rd & emp);

`ifdef SYNC_FIFO_FWFT_EN
         // d_out mirrors the head: refill from the next slot, or from d_in when the written word becomes the head.
         if (rd_ok) begin
            if (count >= CW'(2))
               d_out <= mem[rd_ptr_inc];
            else if (wr_ok)
               d_out <= d_in;
         end else if (wr_ok && emp) begin
            d_out <= d_in;
         end
`else
         if (rd_ok)
            d_out <= mem[rd_ptr];
`endif
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=4, AF=3, AE=1), scoreboard queue plus directed constant checks.
// Covers both the standard and the SYNC_FIFO_FWFT_EN builds.
module tb_sync_fifo_param;

   logic       clk;
   logic       rst;
   logic       wr;
   logic [7:0] d_in;
   logic       rd;
   logic [7:0] d_out;
   logic       full;
   logic       emp;
   logic       a_full;
   logic       a_emp;
   logic [2:0] count;
   logic       ovf;
   logic       udf;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] q [$];
   logic [7:0] m_dout;
   bit         m_ovf;
   bit         m_udf;

   sync_fifo_param #(
      .WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)
   ) dut (
      .clk(clk), .rst(rst), .wr(wr), .d_in(d_in), .rd(rd), .d_out(d_out),
      .full(full), .emp(emp), .a_full(a_full), .a_emp(a_emp),
      .count(count), .ovf(ovf), .udf(udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int sz = q.size();
      check({tag, ".count"},  32'(count),  32'(sz));
      check({tag, ".full"},   32'(full),   32'(sz == 4));
      check({tag, ".emp"},    32'(emp),    32'(sz == 0));
      check({tag, ".a_full"}, 32'(a_full), 32'(sz >= 3));
      check({tag, ".a_emp"},  32'(a_emp),  32'(sz <= 1));
      check({tag, ".ovf"},    32'(ovf),    32'(m_ovf));
      check({tag, ".udf"},    32'(udf),    32'(m_udf));
      check({tag, ".d_out"},  32'(d_out),  32'(m_dout));
   endtask

   // One clock: apply inputs, advance the scoreboard from pre-edge state, compare 1 time unit after the edge.
   task automatic drive(input string tag, input bit r_st, input bit w, input logic [7:0] d, input bit r);
      bit m_full, m_emp, wok, rok;
      rst = r_st; wr = w; d_in = d; rd = r;
      @(posedge clk);
      #1;
      rst = 1'b0; wr = 1'b0; rd = 1'b0;
      if (r_st) begin
         q.delete();
         m_dout = '0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
      end else begin
         m_full = (q.size() == 4);
         m_emp  = (q.size() == 0);
         wok    = w && (!m_full || r);
         rok    = r && !m_emp;
         if (w && !wok) m_ovf = 1'b1;
         if (r && m_emp) m_udf = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
         if (rok) void'(q.pop_front());
         if (wok) q.push_back(d);
         if (q.size() > 0) m_dout = q[0];
`else
         if (rok) m_dout = q.pop_front();
         if (wok) q.push_back(d);
`endif
      end
      check_all(tag);
   endtask

   logic [7:0] fill_v [4];

   initial begin
      fill_v = '{8'd12, 8'd198, 8'd101, 8'd78};
      rst = 1'b1; wr = 1'b0; rd = 1'b0; d_in = '0;
      m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;

      // Reset held for two cycles
      drive("reset0", 1, 0, 8'd0, 0);
      drive("reset1", 1, 0, 8'd0, 0);
      check("reset_dout", 32'(d_out), 32'd0);
      check("reset_emp", 32'(emp), 32'd1);

      // Fill to full, then drain in order
      for (int i = 0; i < 4; i++) begin
         drive("fill_wr", 0, 1, fill_v[i], 0);
         check("fill_count", 32'(count), 32'(i + 1));
         if (i == 1) check("a_full_at2", 32'(a_full), 32'd0);
         if (i == 2) check("a_full_at3", 32'(a_full), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
         if (i == 0) check("fwft_first_head", 32'(d_out), 32'd12);
`endif
      end
      check("fill_full", 32'(full), 32'd1);
      for (int i = 0; i < 4; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         check("fill_head", 32'(d_out), 32'(fill_v[i]));
`endif
         drive("fill_rd", 0, 0, 8'd0, 1);
`ifndef SYNC_FIFO_FWFT_EN
         check("fill_rd_data", 32'(d_out), 32'(fill_v[i]));
`endif
      end
      check("drain_emp", 32'(emp), 32'd1);

      // Overflow: write into full FIFO is dropped and ovf sticks
      for (int i = 0; i < 4; i++) drive("ovf_fill", 0, 1, 8'(i + 1), 0);
      drive("ovf_wr", 0, 1, 8'd55, 0);
      check("ovf_set", 32'(ovf), 32'd1);
      check("ovf_count", 32'(count), 32'd4);
      for (int i = 0; i < 4; i++) begin
         drive("ovf_rd", 0, 0, 8'd0, 1);
         check("ovf_no55", 32'(d_out == 8'd55), 32'd0);
      end
      check("ovf_sticky", 32'(ovf), 32'd1);

      // Underflow: read while empty, then simultaneous rd/wr on empty
      drive("udf_rd", 0, 0, 8'd0, 1);
      check("udf_set", 32'(udf), 32'd1);
      drive("udf_rdwr", 0, 1, 8'd9, 1);
      check("udf_rdwr_count", 32'(count), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
      check("udf_head9", 32'(d_out), 32'd9);
`endif
      drive("udf_rd9", 0, 0, 8'd0, 1);
`ifndef SYNC_FIFO_FWFT_EN
      check("udf_rd9_data", 32'(d_out), 32'd9);
`endif

      // Simultaneous rd/wr while full, repeated to wrap the pointers
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 4; i++) drive("wrap_fill", 0, 1, 8'($urandom_range(0, 255)), 0);
         for (int i = 0; i < 3; i++) begin
            drive("wrap_rdwr", 0, 1, 8'(200 + 10 * p + i), 1);
            check("wrap_rdwr_count", 32'(count), 32'd4);
         end
         for (int i = 0; i < 4; i++) drive("wrap_drain", 0, 0, 8'd0, 1);
      end
`ifdef SYNC_FIFO_FWFT_EN
      check("wrap_last_hold", 32'(d_out), 32'd222);
`else
      check("wrap_last", 32'(d_out), 32'd222);
`endif

      // Random traffic against the scoreboard
      for (int i = 0; i < 300; i++)
         drive("rand", 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

      // Mid-operation reset with a concurrent write
      drive("mid_pre_rst", 1, 0, 8'd0, 0);
      for (int i = 0; i < 3; i++) drive("mid_fill", 0, 1, 8'(40 + i), 0);
      check("mid_count3", 32'(count), 32'd3);
      drive("mid_rst", 1, 1, 8'h33, 0);
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_emp", 32'(emp), 32'd1);
      drive("mid_wr", 0, 1, 8'd77, 0);
`ifdef SYNC_FIFO_FWFT_EN
      check("mid_head77", 32'(d_out), 32'd77);
`endif
      drive("mid_rd", 0, 0, 8'd0, 1);
`ifndef SYNC_FIFO_FWFT_EN
      check("mid_rd77", 32'(d_out), 32'd77);
`endif
      check("mid_emp_end", 32'(emp), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
